// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: latches a 32-bit display word and scans it as hex digits
// onto a common-anode 7-segment bank (active-low anodes and segments).
// The digit-0 decimal point mirrors the CPU pause flag.
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seg7_scan_driver #(
    parameter int SCAN_DIV = 1000,
    parameter int DIGITS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic        load,
    input  logic        blank,
    input  logic        pause,
    output logic [7:0]  seg_7_val,
    output logic [7:0]  an
);

    localparam logic [15:0] CNT_MAX = 16'(SCAN_DIV - 1);
    localparam logic [2:0]  IDX_MAX = 3'(DIGITS - 1);

    logic [31:0] val_q, val_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  an_q, an_d;
    logic [7:0]  seg_q, seg_d;
    logic [3:0]  nib;
    logic        lz_blank;

    function automatic logic [6:0] hexdec(input logic [3:0] h);
        case (h)
            4'h0: hexdec = 7'h40;
            4'h1: hexdec = 7'h79;
            4'h2: hexdec = 7'h24;
            4'h3: hexdec = 7'h30;
            4'h4: hexdec = 7'h19;
            4'h5: hexdec = 7'h12;
            4'h6: hexdec = 7'h02;
            4'h7: hexdec = 7'h78;
            4'h8: hexdec = 7'h00;
            4'h9: hexdec = 7'h10;
            4'hA: hexdec = 7'h08;
            4'hB: hexdec = 7'h03;
            4'hC: hexdec = 7'h46;
            4'hD: hexdec = 7'h21;
            4'hE: hexdec = 7'h06;
            default: hexdec = 7'h0E;
        endcase
    endfunction

    // Nibble shown in the current slot, taken from the latched word.
    assign nib = 4'(val_q >> {idx_q, 2'b00});

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [7:0] zero_from;
    logic       acc;

    // zero_from[k] is set when nibbles k..DIGITS-1 of the latched word are all zero.
    always_comb begin
        zero_from = '0;
        acc       = 1'b1;
        for (int k = 7; k >= 0; k--) begin
            if (k < DIGITS) begin
                acc          = acc & (val_q[4*k +: 4] == 4'h0);
                zero_from[k] = acc;
            end
        end
    end

    // Digit 0 always shows, so a zero word still reads "0".
    assign lz_blank = (idx_q != 3'd0) && zero_from[idx_q];
`else
    assign lz_blank = 1'b0;
`endif

    // Next-state: latch, slot counter, digit index, and the registered output image.
    always_comb begin
        val_d = load ? value : val_q;
        cnt_d = cnt_q + 16'd1;
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;
        end
        an_d       = ~(8'b1 << idx_q);
        seg_d[6:0] = lz_blank ? 7'h7F : hexdec(nib);
        seg_d[7]   = ~(pause && (idx_q == 3'd0));
        if (blank) begin
            an_d  = 8'hFF;
            seg_d = 8'hFF;
        end
    end

    // All state updates on the rising edge; reset darkens the display.
    always_ff @(posedge clk) begin
        if (!rst) begin
            val_q <= '0;
            cnt_q <= '0;
            idx_q <= '0;
            an_q  <= 8'hFF;
            seg_q <= 8'hFF;
        end else begin
            val_q <= val_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an        = an_q;
    assign seg_7_val = seg_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream display stage of RiscvCPU.
- Latches a 32-bit value selected by the CPU's display_sel mux and time-multiplexes it as 8 hex digits onto the board's common-anode 7-segment bank.
- Drives the seg_7_val and an top-level outputs.
- Also shows the CPU pause state on the digit-0 decimal point.

Parameters:
- SCAN_DIV, 1000: clk cycles per digit slot; legal range 1..65535.
- DIGITS, 8: number of active digits; legal range 1..8. Unused anodes are held off.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- value  in  32  display data; nibble k drives digit k (digit 0 = value[3:0])
- load  in  1  when 1, capture value into the internal display register
- blank  in  1  when 1, all anodes off
- pause  in  1  CPU pause flag; lights the digit-0 decimal point
- seg_7_val  out  8  active-low segments: [7]=dp, [6:0]=g..a
- an  out  8  active-low one-hot anode enables; an[k] selects digit k

Behaviour:
- All state is registered. Reset applies on a rising clk edge with rst=0 and overrides every other input.
- Reset values:
  - val_reg=0, cnt=0, idx=0
  - an=8'hFF, seg_7_val=8'hFF (display dark)
- Value latch:
  - load=1 sets val_reg<=value on that edge.
  - The new value appears on the outputs no earlier than the following edge.
  - load=0 holds val_reg.
- Scan counter:
  - cnt counts 0..SCAN_DIV-1.
  - At cnt==SCAN_DIV-1: cnt<=0 and idx<=(idx==DIGITS-1)?0:idx+1. Otherwise cnt<=cnt+1.
  - SCAN_DIV=1 advances idx every cycle.
  - The wrap from DIGITS-1 to 0 is the only non-increment transition.
- Output register (one-cycle lag behind idx/val_reg):
  - an <= ~(8'b1<<idx).
  - seg_7_val[6:0] <= hexdec(val_reg[4*idx+:4]).
  - seg_7_val[7] <= ~(pause && idx==0).
- Hex decode table (bits [6:0]):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- blank=1: an<=8'hFF and seg_7_val<=8'hFF on the same edge. cnt and idx keep running, and the latch still honours load.
- Simultaneous events:
  - load on the same edge as an idx advance: the output register samples the old val_reg; the new value is shown from the next edge.
  - pause changes mid-slot: dp updates one cycle later.
- Reset mid-scan: the next edge after reset deasserts drives digit 0 with val_reg=0, i.e. an=8'hFE and seg_7_val=8'hC0, or 8'h40 if pause=1.
- No combinational path from any input to any output.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - A digit k>0 is blanked (seg_7_val[6:0]=7'h7F, anode still enabled) when val_reg nibbles k..DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - The dp rule is unchanged.
- Undefined: every digit shows its hex nibble, including leading zeros.

Test Plan:
- Reset/first digit: hold rst=0 for 3 cycles, then release with SCAN_DIV=4, pause=0 -> an=FF and seg=FF during reset; one edge after release an=FE, seg=C0. Thereafter an steps FD, FB, … every 4 cycles and wraps from 7F back to FE.
- Decode sweep: load 32'h89ABCDEF, SCAN_DIV=1 -> per digit 0..7, seg[6:0] = 0E, 06, 21, 46, 03, 08, 10, 00.
- Pause dp: pause=1 with value 0 -> seg=40 only while an=FE; seg=C0 on all other digits. Deassert pause -> dp off one cycle later.
- Load at wrap: SCAN_DIV=2, load 32'h1 on the edge where idx advances -> that slot shows the previous nibble; the new value is visible from the next edge, with no glitch on an.
- Blank and DIGITS=4: blank=1 for 10 cycles -> an=FF and seg=FF, and the scan resumes at the correct advanced idx. With DIGITS=4, an cycles FE, FD, FB, F7 only.
- With SEG7_LEADING_ZERO_BLANK_EN, value=32'h00000A05 -> digits 3..7 show seg[6:0]=7F, digits 0..2 show 12, 40, 08. Without the macro, digits 3..7 show 40.
